// File: rtl/rx_frame_checker.sv
// GMII receive frame checker: preamble/SFD lock, payload forwarding, length check and per-frame verdict.
// Build option: define FCS_CHECK_EN to compile the CRC-32 FCS check; without it err_code[2] is tied to 0.
module rx_frame_checker #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        Clk,
    input  logic        mr_main_reset,
    input  logic        RX_DV,
    input  logic [7:0]  RXD,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        sof,
    output logic        frame_ok,
    output logic        frame_bad,
    output logic [3:0]  err_code,
    output logic [10:0] frame_len,
    output logic [15:0] good_count,
    output logic [15:0] bad_count,
    output logic [1:0]  fsm_state
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PREAMBLE = 2'd1;
    localparam logic [1:0] S_DATA     = 2'd2;
    localparam logic [1:0] S_DROP     = 2'd3;

    localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
    localparam logic [10:0] LEN_SAT = 11'h7FF;

    logic [1:0]  state;
    logic [10:0] len;
    // Cleared by reset: a frame already in flight when reset releases must not be locked onto.
    logic        armed;

    logic        issue;
    logic [3:0]  issue_err;
    logic [10:0] issue_len;
    logic [3:0]  verdict_err;

`ifdef FCS_CHECK_EN
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    logic [31:0] crc;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction
`endif

    assign fsm_state = state;

    always_comb begin
        verdict_err    = 4'b0000;
        verdict_err[0] = (len < MIN_L);
        verdict_err[1] = (len > MAX_L);
`ifdef FCS_CHECK_EN
        verdict_err[2] = (crc != CRC_RESIDUE);
`endif
    end

    // A verdict is issued on the edge that samples RX_DV=0 in any non-idle state.
    always_comb begin
        issue     = 1'b0;
        issue_err = 4'b0000;
        issue_len = 11'd0;
        if (!RX_DV) begin
            case (state)
                S_PREAMBLE, S_DROP: begin
                    issue     = 1'b1;
                    issue_err = 4'b1000;
                end
                S_DATA: begin
                    issue     = 1'b1;
                    issue_err = verdict_err;
                    issue_len = len;
                end
                default: ;
            endcase
        end
    end

    // data_valid qualifies data_out for one cycle per forwarded byte; there is no backpressure.
    always_ff @(posedge Clk) begin
        if (mr_main_reset) begin
            state      <= S_IDLE;
            armed      <= 1'b0;
            len        <= 11'd0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            sof        <= 1'b0;
            frame_ok   <= 1'b0;
            frame_bad  <= 1'b0;
            err_code   <= 4'b0000;
            frame_len  <= 11'd0;
            good_count <= 16'd0;
            bad_count  <= 16'd0;
`ifdef FCS_CHECK_EN
            crc        <= 32'hFFFFFFFF;
`endif
        end else begin
            data_valid <= 1'b0;
            sof        <= 1'b0;
            frame_ok   <= 1'b0;
            frame_bad  <= 1'b0;
            armed      <= 1'b1;

            if (issue) begin
                err_code  <= issue_err;
                frame_len <= issue_len;
                if (issue_err == 4'b0000) begin
                    frame_ok   <= 1'b1;
                    good_count <= good_count + 16'd1;
                end else begin
                    frame_bad <= 1'b1;
                    bad_count <= bad_count + 16'd1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (RX_DV) begin
                        state <= (armed && RXD == 8'h55) ? S_PREAMBLE : S_DROP;
                    end
                end
                S_PREAMBLE: begin
                    if (!RX_DV) begin
                        state <= S_IDLE;
                    end else if (RXD == 8'hD5) begin
                        state <= S_DATA;
                        len   <= 11'd0;
`ifdef FCS_CHECK_EN
                        crc   <= 32'hFFFFFFFF;
`endif
                    end else if (RXD != 8'h55) begin
                        state <= S_DROP;
                    end
                end
                S_DATA: begin
                    if (!RX_DV) begin
                        state <= S_IDLE;
                    end else begin
                        data_out   <= RXD;
                        data_valid <= 1'b1;
                        sof        <= (len == 11'd0);
                        len        <= (len == LEN_SAT) ? len : len + 11'd1;
`ifdef FCS_CHECK_EN
                        crc        <= crc_byte(crc, RXD);
`endif
                    end
                end
                default: begin
                    if (!RX_DV) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_checker.sv
// Scoreboard bench for rx_frame_checker: directed frames, expected bytes and verdicts queued at stimulus time.
module tb_rx_frame_checker;

    logic        Clk;
    logic        mr_main_reset;
    logic        RX_DV;
    logic [7:0]  RXD;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        sof;
    logic        frame_ok;
    logic        frame_bad;
    logic [3:0]  err_code;
    logic [10:0] frame_len;
    logic [15:0] good_count;
    logic [15:0] bad_count;
    logic [1:0]  fsm_state;

`ifdef FCS_CHECK_EN
    localparam logic FCS_ON = 1'b1;
`else
    localparam logic FCS_ON = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    logic [8:0]  exp_d_q[$];
    logic [47:0] exp_v_q[$];
    logic [15:0] exp_good = 16'd0;
    logic [15:0] exp_bad  = 16'd0;
    logic [7:0]  fb [0:2199];

    rx_frame_checker dut (
        .Clk(Clk), .mr_main_reset(mr_main_reset), .RX_DV(RX_DV), .RXD(RXD),
        .data_out(data_out), .data_valid(data_valid), .sof(sof),
        .frame_ok(frame_ok), .frame_bad(frame_bad), .err_code(err_code),
        .frame_len(frame_len), .good_count(good_count), .bad_count(bad_count),
        .fsm_state(fsm_state)
    );

    // Clock and reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Driver tasks
    task automatic drive(input logic dv, input logic [7:0] d);
        @(posedge Clk);
        #1;
        RX_DV = dv;
        RXD   = d;
    endtask

    task automatic build(input int n, input int seed, input bit corrupt);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) begin
            fb[i] = 8'((i * 29 + seed) & 255);
            c = crc_step(c, fb[i]);
        end
        c = ~c;
        fb[n-4] = c[7:0];
        fb[n-3] = c[15:8];
        fb[n-2] = c[23:16];
        fb[n-1] = c[31:24];
        if (corrupt) fb[n-1] = fb[n-1] ^ 8'h01;
    endtask

    task automatic push_verdict(input logic [3:0] e_err, input logic [10:0] e_len);
        logic ok;
        ok = (e_err == 4'b0000);
        if (ok) exp_good = exp_good + 16'd1;
        else    exp_bad  = exp_bad + 16'd1;
        exp_v_q.push_back({ok, e_err, e_len, exp_good, exp_bad});
    endtask

    task automatic send_preamble();
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
    endtask

    task automatic send_frame(input int n, input bit corrupt, input logic [3:0] e_err,
                              input logic [10:0] e_len, input int n_idle, input int seed);
        build(n, seed, corrupt);
        send_preamble();
        for (int i = 0; i < n; i++) begin
            exp_d_q.push_back({(i == 0), fb[i]});
            drive(1'b1, fb[i]);
        end
        push_verdict(e_err, e_len);
        for (int i = 0; i < n_idle; i++) drive(1'b0, 8'h00);
    endtask

    // Scoreboard monitor
    always @(negedge Clk) begin
        logic [8:0]  d;
        logic [47:0] v;
        if (frame_ok && frame_bad) chk("ok_bad_exclusive", 1, 0);
        if (data_valid) begin
            if (exp_d_q.size() == 0) begin
                chk("unexpected_data_valid", {24'h0, data_out}, 32'hFFFFFFFF);
            end else begin
                d = exp_d_q.pop_front();
                chk("data_out", {24'h0, data_out}, {24'h0, d[7:0]});
                chk("sof", {31'h0, sof}, {31'h0, d[8]});
            end
        end
        if (frame_ok || frame_bad) begin
            if (exp_v_q.size() == 0) begin
                chk("unexpected_verdict", {28'h0, err_code}, 32'hFFFFFFFF);
            end else begin
                v = exp_v_q.pop_front();
                chk("frame_ok", {31'h0, frame_ok}, {31'h0, v[47]});
                chk("frame_bad", {31'h0, frame_bad}, {31'h0, !v[47]});
                chk("err_code", {28'h0, err_code}, {28'h0, v[46:43]});
                chk("frame_len", {21'h0, frame_len}, {21'h0, v[42:32]});
                chk("good_count", {16'h0, good_count}, {16'h0, v[31:16]});
                chk("bad_count", {16'h0, bad_count}, {16'h0, v[15:0]});
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_data_out"}, {24'h0, data_out}, 0);
        chk({tag, "_data_valid"}, {31'h0, data_valid}, 0);
        chk({tag, "_sof"}, {31'h0, sof}, 0);
        chk({tag, "_frame_ok"}, {31'h0, frame_ok}, 0);
        chk({tag, "_frame_bad"}, {31'h0, frame_bad}, 0);
        chk({tag, "_err_code"}, {28'h0, err_code}, 0);
        chk({tag, "_frame_len"}, {21'h0, frame_len}, 0);
        chk({tag, "_good_count"}, {16'h0, good_count}, 0);
        chk({tag, "_bad_count"}, {16'h0, bad_count}, 0);
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    initial begin
        #2_000_000;
        chk("watchdog_timeout", 1, 0);
        finish_run();
    end

    initial begin
        int waited;
        mr_main_reset = 1'b1;
        RX_DV = 1'b0;
        RXD = 8'h00;
        repeat (3) @(posedge Clk);
        #1;
        check_all_zero("reset");
        mr_main_reset = 1'b0;
        repeat (3) drive(1'b0, 8'h00);

        // Good 64-byte frame, then FCS-corrupted copy
        send_frame(64, 0, 4'b0000, 11'd64, 3, 1);
        send_frame(64, 1, {1'b0, FCS_ON, 2'b00}, 11'd64, 3, 1);
        // Runt with valid FCS, runt with corrupted FCS, oversize, saturating length
        send_frame(63, 0, 4'b0001, 11'd63, 3, 2);
        send_frame(10, 1, {1'b0, FCS_ON, 2'b01}, 11'd10, 3, 3);
        send_frame(1519, 0, 4'b0010, 11'd1519, 3, 4);
        send_frame(2100, 0, 4'b0010, 11'd2047, 3, 5);
        send_frame(1518, 0, 4'b0000, 11'd1518, 3, 6);

        // Bad preamble byte inside the preamble
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h5A);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'h11);
        push_verdict(4'b1000, 11'd0);
        repeat (3) drive(1'b0, 8'h00);

        // Frame starting with a non-preamble byte from idle
        drive(1'b1, 8'hD5);
        drive(1'b1, 8'h22);
        push_verdict(4'b1000, 11'd0);
        repeat (3) drive(1'b0, 8'h00);

        // Preamble cut short by RX_DV falling
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h55);
        push_verdict(4'b1000, 11'd0);
        repeat (3) drive(1'b0, 8'h00);

        // Reset pulsed at byte 30 with RX_DV held high
        build(64, 7, 0);
        send_preamble();
        for (int i = 0; i < 30; i++) begin
            exp_d_q.push_back({(i == 0), fb[i]});
            drive(1'b1, fb[i]);
        end
        @(posedge Clk);
        #1;
        mr_main_reset = 1'b1;
        RX_DV = 1'b1;
        RXD = fb[30];
        @(posedge Clk);
        #1;
        check_all_zero("midreset");
        exp_good = 16'd0;
        exp_bad = 16'd0;
        mr_main_reset = 1'b0;
        RXD = fb[31];
        @(posedge Clk);
        #1;
        chk("drop_after_reset_state", {30'h0, fsm_state}, 32'd3);
        chk("drop_no_data_valid", {31'h0, data_valid}, 0);
        for (int i = 32; i < 64; i++) drive(1'b1, fb[i]);
        push_verdict(4'b1000, 11'd0);
        repeat (3) drive(1'b0, 8'h00);

        // Clean frame after reset, then two back-to-back frames with one idle cycle
        send_frame(64, 0, 4'b0000, 11'd64, 3, 8);
        send_frame(64, 0, 4'b0000, 11'd64, 1, 9);
        send_frame(64, 0, 4'b0000, 11'd64, 4, 10);

        waited = 0;
        while ((exp_d_q.size() != 0 || exp_v_q.size() != 0) && waited < 50) begin
            @(posedge Clk);
            waited++;
        end
        chk("data_queue_drained", exp_d_q.size(), 0);
        chk("verdict_queue_drained", exp_v_q.size(), 0);
        finish_run();
    end

endmodule
